id_ex_pipeline_register: RTL and testbench
==========================================

Name: id_ex_pipeline_register

Overview:
ID/EX stage register of the 5-stage RISC-V core. It latches decoded control, operands, immediate and register addresses from ID and presents them to EX. It consumes the load-use hazard flag by inserting a bubble, honours data-cache memory stalls by holding, and honours branch flushes. Its registered EX-side memRead and rd address feed back into the load-use hazard detector.

Parameters:
DATA_W, 32, operand, immediate and PC width
BUBBLE_CNT_W, 16, width of the load-use bubble counter

Ports:
clk_i  input  1  core clock
rst_i  input  1  reset; asynchronous, active-high
memStall_i  input  1  data-cache stall; freeze the register
hazard_i  input  1  load-use hazard from the hazard detector; insert bubble
flush_i  input  1  branch-taken flush; insert bubble
ID_valid_i  input  1  ID holds a real instruction
ID_regWrite_i  input  1  control: register write
ID_memToReg_i  input  1  control: writeback selects memory
ID_memRead_i  input  1  control: load
ID_memWrite_i  input  1  control: store
ID_aluSrc_i  input  1  control: ALU B operand selects immediate
ID_aluOp_i  input  2  control: ALU op class
ID_pc_i  input  DATA_W  instruction PC
ID_rs1Data_i  input  DATA_W  register file read data 1
ID_rs2Data_i  input  DATA_W  register file read data 2
ID_imm_i  input  DATA_W  sign-extended immediate
ID_funct_i  input  10  {funct7, funct3}
ID_rs1Addr_i  input  5  rs1 index
ID_rs2Addr_i  input  5  rs2 index
ID_rdAddr_i  input  5  rd index
EX_* outputs  output  same widths  registered copies of every ID_* input above (EX_valid_o, EX_regWrite_o, ... EX_rdAddr_o)
bubbleCount_o  output  BUBBLE_CNT_W  saturating count of load-use bubbles inserted

Behaviour:
- Reset (rst_i=1, asynchronous): every output is 0, including EX_valid_o, all control bits, all data and address fields, and bubbleCount_o. Release is synchronous to the next clk_i edge.
- Latency: 1 cycle from ID_* to EX_*.
- Per rising edge, the priority order is:
  1) memStall_i=1: HOLD. All EX_* outputs and bubbleCount_o keep their values, even if hazard_i or flush_i is set.
  2) else flush_i=1 or hazard_i=1: BUBBLE.
     - EX_valid_o, regWrite, memToReg, memRead, memWrite, aluSrc and aluOp are set to 0.
     - EX_rdAddr_o, EX_rs1Addr_o and EX_rs2Addr_o are set to 0, so forwarding and hazard logic see x0.
     - Data fields, PC and funct are set to 0.
  3) else LOAD: every EX_* field takes its ID_* value. If ID_valid_i=0, the control bits and EX_rdAddr_o are forced to 0.
- bubbleCount_o:
  - Increments by 1 on a BUBBLE cycle where hazard_i=1, whether or not flush_i is also set.
  - Does not increment on a flush-only bubble.
  - Saturates at all-ones with no wrap. It is cleared only by reset.
- hazard_i and flush_i together: a single bubble, and the counter increments.
- Back-to-back hazard_i cycles: one bubble per cycle, and the counter increments each cycle.
- A stall lasting N cycles followed by a hazard: the bubble is inserted on the first non-stalled edge only.
- Reset asserted mid-stall or mid-bubble: outputs clear immediately, and the register resumes in LOAD after release.
- No combinational path from any input to any output.

Decomposition:
- Shared package:
  - ALUOp encodings (LOAD_STORE=00, BRANCH=01, RTYPE=10, ITYPE=11).
  - Control bundle width constant CTRL_W=7 and field offsets.
  - Register address width REG_ADDR_W=5.
- One natural sub-module, pipe_reg_en_clr: a width-parameterised register with async reset, hold enable and synchronous clear. It is instantiated once for the control and address bundle and once for the data bundle. The counter logic stays in the top module.

Test Plan:
- Reset with all ID_* inputs nonzero (regWrite=1, rdAddr=5, rs1Data=0xDEADBEEF) -> all EX_* outputs 0 and bubbleCount_o=0 while rst_i=1, including mid-cycle assertion.
- LOAD: lw x5,0(x1) decoded (memRead=1, memToReg=1, regWrite=1, rdAddr=5, imm=0) -> next edge EX_memRead_o=1, EX_rdAddr_o=5, EX_valid_o=1.
- Load-use: hazard_i=1 for one cycle with add x6,x5,x5 in ID -> EX control bits all 0, EX_rdAddr_o=0, bubbleCount_o=1. On the next edge with hazard_i=0, the add is loaded with rs1Addr=5.
- Stall priority: memStall_i=1 for 3 cycles with hazard_i=1 and flush_i=1 -> EX_* unchanged for all 3 edges and bubbleCount_o unchanged. On the first edge after the stall, a bubble and counter +1.
- Flush only: flush_i=1, hazard_i=0 with sw in ID -> EX_memWrite_o=0, EX_valid_o=0, bubbleCount_o unchanged. flush_i and hazard_i together -> one bubble, counter +1.
- Saturation with BUBBLE_CNT_W=4: 17 hazard cycles -> bubbleCount_o reaches 15 and stays 15.

Source files
------------

// File: rtl/id_ex_pipeline_register_pkg.sv
// Shared definitions for the ID/EX pipeline register: ALU op class encodings,
// control bundle layout and register address width.
package id_ex_pipeline_register_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned FUNCT_W    = 10;
  localparam int unsigned ALU_OP_W   = 2;
  localparam int unsigned CTRL_W     = 7;

  // Bit offsets of each control field inside the CTRL_W-wide control bundle
  localparam int unsigned CTRL_ALU_OP_LSB  = 0;
  localparam int unsigned CTRL_ALU_SRC     = 2;
  localparam int unsigned CTRL_MEM_WRITE   = 3;
  localparam int unsigned CTRL_MEM_READ    = 4;
  localparam int unsigned CTRL_MEM_TO_REG  = 5;
  localparam int unsigned CTRL_REG_WRITE   = 6;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_LOAD_STORE = 2'b00,
    ALU_BRANCH     = 2'b01,
    ALU_RTYPE      = 2'b10,
    ALU_ITYPE      = 2'b11
  } alu_op_e;

  // Field order matches the CTRL_* offsets above (MSB first)
  typedef struct packed {
    logic    reg_write;
    logic    mem_to_reg;
    logic    mem_read;
    logic    mem_write;
    logic    alu_src;
    alu_op_e alu_op;
  } ctrl_t;

  // Control plus register-address bundle carried through the stage
  typedef struct packed {
    logic                  valid;
    ctrl_t                 ctrl;
    logic [REG_ADDR_W-1:0] rs1_addr;
    logic [REG_ADDR_W-1:0] rs2_addr;
    logic [REG_ADDR_W-1:0] rd_addr;
  } ca_bundle_t;

  localparam int unsigned CA_W = $bits(ca_bundle_t);

endpackage

// File: rtl/id_ex_pipeline_register_pipe_reg_en_clr.sv
// Width-parameterised pipeline register.
// Ports: clk/rst (async, active-high), en (load when 1, hold when 0),
// clr (synchronous clear, effective only when en=1), d/q data.
module pipe_reg_en_clr #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Hold has priority over clear so a stalled stage never drops its contents
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= clr ? '0 : d;
    end
  end

endmodule

// File: rtl/id_ex_pipeline_register.sv
// ID/EX stage register of the 5-stage RISC-V core.
// Inputs:  clk_i, rst_i (async active-high), memStall_i (hold), hazard_i and
//          flush_i (bubble), ID_* decoded instruction fields.
// Outputs: EX_* registered copies of the ID_* fields, bubbleCount_o
//          saturating count of load-use bubbles.
module id_ex_pipeline_register
  import id_ex_pipeline_register_pkg::*;
#(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned BUBBLE_CNT_W = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    memStall_i,
  input  logic                    hazard_i,
  input  logic                    flush_i,
  input  logic                    ID_valid_i,
  input  logic                    ID_regWrite_i,
  input  logic                    ID_memToReg_i,
  input  logic                    ID_memRead_i,
  input  logic                    ID_memWrite_i,
  input  logic                    ID_aluSrc_i,
  input  logic [ALU_OP_W-1:0]     ID_aluOp_i,
  input  logic [DATA_W-1:0]       ID_pc_i,
  input  logic [DATA_W-1:0]       ID_rs1Data_i,
  input  logic [DATA_W-1:0]       ID_rs2Data_i,
  input  logic [DATA_W-1:0]       ID_imm_i,
  input  logic [FUNCT_W-1:0]      ID_funct_i,
  input  logic [REG_ADDR_W-1:0]   ID_rs1Addr_i,
  input  logic [REG_ADDR_W-1:0]   ID_rs2Addr_i,
  input  logic [REG_ADDR_W-1:0]   ID_rdAddr_i,
  output logic                    EX_valid_o,
  output logic                    EX_regWrite_o,
  output logic                    EX_memToReg_o,
  output logic                    EX_memRead_o,
  output logic                    EX_memWrite_o,
  output logic                    EX_aluSrc_o,
  output logic [ALU_OP_W-1:0]     EX_aluOp_o,
  output logic [DATA_W-1:0]       EX_pc_o,
  output logic [DATA_W-1:0]       EX_rs1Data_o,
  output logic [DATA_W-1:0]       EX_rs2Data_o,
  output logic [DATA_W-1:0]       EX_imm_o,
  output logic [FUNCT_W-1:0]      EX_funct_o,
  output logic [REG_ADDR_W-1:0]   EX_rs1Addr_o,
  output logic [REG_ADDR_W-1:0]   EX_rs2Addr_o,
  output logic [REG_ADDR_W-1:0]   EX_rdAddr_o,
  output logic [BUBBLE_CNT_W-1:0] bubbleCount_o
);

  localparam int unsigned DATA_BUNDLE_W = 4 * DATA_W + FUNCT_W;

  ca_bundle_t               ca_d;
  ca_bundle_t               ca_q;
  logic [CA_W-1:0]          ca_q_bits;
  logic [DATA_BUNDLE_W-1:0] data_d;
  logic [DATA_BUNDLE_W-1:0] data_q;
  logic                     load_en;
  logic                     bubble;
  logic [BUBBLE_CNT_W-1:0]  bubble_cnt;

  assign load_en = ~memStall_i;
  assign bubble  = flush_i | hazard_i;

  // An invalid ID slot must not write anything, so its control and rd are zeroed
  always_comb begin
    ca_d                 = '0;
    ca_d.valid           = ID_valid_i;
    ca_d.ctrl.reg_write  = ID_regWrite_i & ID_valid_i;
    ca_d.ctrl.mem_to_reg = ID_memToReg_i & ID_valid_i;
    ca_d.ctrl.mem_read   = ID_memRead_i  & ID_valid_i;
    ca_d.ctrl.mem_write  = ID_memWrite_i & ID_valid_i;
    ca_d.ctrl.alu_src    = ID_aluSrc_i   & ID_valid_i;
    ca_d.ctrl.alu_op     = alu_op_e'(ID_aluOp_i & {ALU_OP_W{ID_valid_i}});
    ca_d.rs1_addr        = ID_rs1Addr_i;
    ca_d.rs2_addr        = ID_rs2Addr_i;
    ca_d.rd_addr         = ID_rdAddr_i & {REG_ADDR_W{ID_valid_i}};
  end

  assign data_d = {ID_pc_i, ID_rs1Data_i, ID_rs2Data_i, ID_imm_i, ID_funct_i};

  // Control and address bundle
  pipe_reg_en_clr #(.W(CA_W)) u_ca_reg (
    .clk (clk_i),
    .rst (rst_i),
    .en  (load_en),
    .clr (bubble),
    .d   (ca_d),
    .q   (ca_q_bits)
  );

  // Operand, immediate, PC and funct bundle
  pipe_reg_en_clr #(.W(DATA_BUNDLE_W)) u_data_reg (
    .clk (clk_i),
    .rst (rst_i),
    .en  (load_en),
    .clr (bubble),
    .d   (data_d),
    .q   (data_q)
  );

  assign ca_q = ca_bundle_t'(ca_q_bits);

  assign EX_valid_o    = ca_q.valid;
  assign EX_regWrite_o = ca_q.ctrl.reg_write;
  assign EX_memToReg_o = ca_q.ctrl.mem_to_reg;
  assign EX_memRead_o  = ca_q.ctrl.mem_read;
  assign EX_memWrite_o = ca_q.ctrl.mem_write;
  assign EX_aluSrc_o   = ca_q.ctrl.alu_src;
  assign EX_aluOp_o    = ca_q.ctrl.alu_op;
  assign EX_rs1Addr_o  = ca_q.rs1_addr;
  assign EX_rs2Addr_o  = ca_q.rs2_addr;
  assign EX_rdAddr_o   = ca_q.rd_addr;

  assign {EX_pc_o, EX_rs1Data_o, EX_rs2Data_o, EX_imm_o, EX_funct_o} = data_q;

  // Load-use bubble counter: counts hazard bubbles only, saturates at all-ones
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bubble_cnt <= '0;
    end else if (load_en && hazard_i && (bubble_cnt != '1)) begin
      bubble_cnt <= bubble_cnt + BUBBLE_CNT_W'(1);
    end
  end

  assign bubbleCount_o = bubble_cnt;

endmodule

// File: tb/tb_id_ex_pipeline_register.sv
// Self-checking bench for id_ex_pipeline_register: a table of directed
// vectors plus hand-written reset and saturation sequences.
module tb_id_ex_pipeline_register;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;

  typedef struct packed {
    logic        valid;
    logic        rw;
    logic        m2r;
    logic        mr;
    logic        mw;
    logic        as;
    logic [1:0]  op;
    logic [31:0] pc;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
    logic [31:0] imm;
    logic [9:0]  funct;
    logic [4:0]  rs1a;
    logic [4:0]  rs2a;
    logic [4:0]  rda;
  } fields_t;

  typedef struct {
    string            name;
    logic             stall;
    logic             hazard;
    logic             flush;
    fields_t          id;
    fields_t          exp;
    logic [CNT_W-1:0] cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic memStall, hazard, flush;
  logic ID_valid, ID_regWrite, ID_memToReg, ID_memRead, ID_memWrite, ID_aluSrc;
  logic [1:0]  ID_aluOp;
  logic [31:0] ID_pc, ID_rs1Data, ID_rs2Data, ID_imm;
  logic [9:0]  ID_funct;
  logic [4:0]  ID_rs1Addr, ID_rs2Addr, ID_rdAddr;
  logic EX_valid, EX_regWrite, EX_memToReg, EX_memRead, EX_memWrite, EX_aluSrc;
  logic [1:0]  EX_aluOp;
  logic [31:0] EX_pc, EX_rs1Data, EX_rs2Data, EX_imm;
  logic [9:0]  EX_funct;
  logic [4:0]  EX_rs1Addr, EX_rs2Addr, EX_rdAddr;
  logic [CNT_W-1:0] bubbleCount;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_pipeline_register #(.DATA_W(DATA_W), .BUBBLE_CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst), .memStall_i(memStall), .hazard_i(hazard), .flush_i(flush),
    .ID_valid_i(ID_valid), .ID_regWrite_i(ID_regWrite), .ID_memToReg_i(ID_memToReg),
    .ID_memRead_i(ID_memRead), .ID_memWrite_i(ID_memWrite), .ID_aluSrc_i(ID_aluSrc),
    .ID_aluOp_i(ID_aluOp), .ID_pc_i(ID_pc), .ID_rs1Data_i(ID_rs1Data),
    .ID_rs2Data_i(ID_rs2Data), .ID_imm_i(ID_imm), .ID_funct_i(ID_funct),
    .ID_rs1Addr_i(ID_rs1Addr), .ID_rs2Addr_i(ID_rs2Addr), .ID_rdAddr_i(ID_rdAddr),
    .EX_valid_o(EX_valid), .EX_regWrite_o(EX_regWrite), .EX_memToReg_o(EX_memToReg),
    .EX_memRead_o(EX_memRead), .EX_memWrite_o(EX_memWrite), .EX_aluSrc_o(EX_aluSrc),
    .EX_aluOp_o(EX_aluOp), .EX_pc_o(EX_pc), .EX_rs1Data_o(EX_rs1Data),
    .EX_rs2Data_o(EX_rs2Data), .EX_imm_o(EX_imm), .EX_funct_o(EX_funct),
    .EX_rs1Addr_o(EX_rs1Addr), .EX_rs2Addr_o(EX_rs2Addr), .EX_rdAddr_o(EX_rdAddr),
    .bubbleCount_o(bubbleCount)
  );

  function automatic fields_t mk(logic v, logic rw, logic m2r, logic mr, logic mw,
                                 logic as, logic [1:0] op, logic [31:0] pc,
                                 logic [31:0] rs1d, logic [31:0] rs2d, logic [31:0] imm,
                                 logic [9:0] funct, logic [4:0] rs1a, logic [4:0] rs2a,
                                 logic [4:0] rda);
    fields_t f;
    f.valid = v;   f.rw = rw;     f.m2r = m2r;   f.mr = mr;       f.mw = mw;
    f.as = as;     f.op = op;     f.pc = pc;     f.rs1d = rs1d;   f.rs2d = rs2d;
    f.imm = imm;   f.funct = funct; f.rs1a = rs1a; f.rs2a = rs2a; f.rda = rda;
    return f;
  endfunction

  function automatic vec_t mkv(string n, logic s, logic h, logic fl, fields_t id,
                               fields_t e, logic [CNT_W-1:0] c);
    vec_t v;
    v.name = n; v.stall = s; v.hazard = h; v.flush = fl; v.id = id; v.exp = e; v.cnt = c;
    return v;
  endfunction

  task automatic drive(fields_t f);
    ID_valid = f.valid; ID_regWrite = f.rw; ID_memToReg = f.m2r; ID_memRead = f.mr;
    ID_memWrite = f.mw; ID_aluSrc = f.as; ID_aluOp = f.op; ID_pc = f.pc;
    ID_rs1Data = f.rs1d; ID_rs2Data = f.rs2d; ID_imm = f.imm; ID_funct = f.funct;
    ID_rs1Addr = f.rs1a; ID_rs2Addr = f.rs2a; ID_rdAddr = f.rda;
  endtask

  task automatic check(string name, fields_t e, logic [CNT_W-1:0] ec);
    fields_t a;
    a = mk(EX_valid, EX_regWrite, EX_memToReg, EX_memRead, EX_memWrite, EX_aluSrc,
           EX_aluOp, EX_pc, EX_rs1Data, EX_rs2Data, EX_imm, EX_funct,
           EX_rs1Addr, EX_rs2Addr, EX_rdAddr);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s fields: got %h want %h", name, a, e);
    end
    checks++;
    if (bubbleCount !== ec) begin
      errors++;
      $display("FAIL %s count: got %0d want %0d", name, bubbleCount, ec);
    end
  endtask

  fields_t lw, add_i, sw, inv, inv_exp, zero, rst_pat;
  vec_t    vecs[13];

  initial begin
    lw      = mk(1, 1, 1, 1, 0, 1, 2'b00, 32'h100, 32'h1000, 32'h0, 32'h0, 10'h002, 5'd1, 5'd0, 5'd5);
    add_i   = mk(1, 1, 0, 0, 0, 0, 2'b10, 32'h104, 32'h11, 32'h11, 32'h0, 10'h000, 5'd5, 5'd5, 5'd6);
    sw      = mk(1, 0, 0, 0, 1, 1, 2'b00, 32'h108, 32'h1000, 32'hCAFE, 32'h8, 10'h002, 5'd1, 5'd2, 5'd8);
    inv     = mk(0, 1, 0, 0, 0, 0, 2'b10, 32'h10C, 32'h22, 32'h33, 32'h0, 10'h100, 5'd3, 5'd4, 5'd7);
    inv_exp = mk(0, 0, 0, 0, 0, 0, 2'b00, 32'h10C, 32'h22, 32'h33, 32'h0, 10'h100, 5'd3, 5'd4, 5'd0);
    zero    = '0;
    rst_pat = mk(1, 1, 1, 1, 1, 1, 2'b11, 32'h200, 32'hDEADBEEF, 32'h5, 32'h7, 10'h3FF, 5'd9, 5'd10, 5'd5);

    vecs[0]  = mkv("load_lw",        0, 0, 0, lw,    lw,      4'd0);
    vecs[1]  = mkv("load_use_bub",   0, 1, 0, add_i, zero,    4'd1);
    vecs[2]  = mkv("load_add",       0, 0, 0, add_i, add_i,   4'd1);
    vecs[3]  = mkv("stall_1",        1, 1, 1, sw,    add_i,   4'd1);
    vecs[4]  = mkv("stall_2",        1, 1, 1, sw,    add_i,   4'd1);
    vecs[5]  = mkv("stall_3",        1, 1, 1, sw,    add_i,   4'd1);
    vecs[6]  = mkv("post_stall_bub", 0, 1, 1, sw,    zero,    4'd2);
    vecs[7]  = mkv("load_sw",        0, 0, 0, sw,    sw,      4'd2);
    vecs[8]  = mkv("flush_only",     0, 0, 1, sw,    zero,    4'd2);
    vecs[9]  = mkv("flush_hazard",   0, 1, 1, lw,    zero,    4'd3);
    vecs[10] = mkv("load_invalid",   0, 0, 0, inv,   inv_exp, 4'd3);
    vecs[11] = mkv("stall_hold",     1, 0, 0, lw,    inv_exp, 4'd3);
    vecs[12] = mkv("load_lw_again",  0, 0, 0, lw,    lw,      4'd3);

    // Reset with busy inputs
    rst = 1'b1; memStall = 1'b0; hazard = 1'b0; flush = 1'b0;
    drive(rst_pat);
    #1;
    check("reset_t0", zero, 4'd0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_held", zero, 4'd0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      memStall = vecs[i].stall;
      hazard   = vecs[i].hazard;
      flush    = vecs[i].flush;
      drive(vecs[i].id);
      @(posedge clk);
      #1;
      check(vecs[i].name, vecs[i].exp, vecs[i].cnt);
    end

    // Mid-cycle reset during a stall clears outputs without waiting for an edge
    memStall = 1'b1; hazard = 1'b1; drive(sw);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check("reset_mid_stall", zero, 4'd0);
    @(posedge clk);
    #1 check("reset_mid_held", zero, 4'd0);
    rst = 1'b0; memStall = 1'b0; hazard = 1'b0;
    drive(add_i);
    @(posedge clk);
    #1 check("resume_load", add_i, 4'd0);

    // Back-to-back hazards: counter climbs to 15 and sticks there
    hazard = 1'b1;
    drive(lw);
    for (int i = 1; i <= 17; i++) begin
      @(posedge clk);
      #1 check($sformatf("sat_%0d", i), zero, (i >= 15) ? 4'd15 : CNT_W'(i));
    end

    // Reset mid-bubble, then normal load resumes
    #2 rst = 1'b1;
    #1 check("reset_mid_bubble", zero, 4'd0);
    #2 rst = 1'b0; hazard = 1'b0;
    drive(sw);
    @(posedge clk);
    #1 check("resume_after_bubble", sw, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
